uart_rx_ctrl: RTL



---
 rtl/uart_rx_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receiver control: oversampled start/data/parity/stop framing with
// 3-sample majority voting, frame-end error reporting and break detection.
// All outputs are registered; configuration is latched at start-bit detection.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    input  logic                  stop_bits,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  break_detect,
    output logic                  busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [PRESCALE_W-1:0] CNT_ZERO  = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] CNT_ONE   = {{(PRESCALE_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0]            BIT_LAST  = 4'(DATA_WIDTH - 1);

    // Even parity over a data word (1 when the word has an odd number of ones).
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] word);
        return ^word;
    endfunction

    // Majority vote of three line samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t                  state_r;
    logic [PRESCALE_W-1:0]   edge_cnt_r;
    logic [PRESCALE_W-1:0]   presc_r;
    logic [3:0]              bit_cnt_r;
    logic                    par_en_r;
    logic                    par_type_r;
    logic                    stop2_r;
    logic [1:0]              samp_r;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic [DATA_WIDTH-1:0]   p_data_r;
    logic                    par_err_r;
    logic                    stop_err_r;
    logic                    all_low_r;
    logic                    data_valid_r;
    logic                    parity_error_r;
    logic                    stop_error_r;
    logic                    break_detect_r;
    logic                    busy_r;

    logic [PRESCALE_W-1:0]   half_s;
    logic [PRESCALE_W-1:0]   dec_cnt_s;
    logic                    dec_s;
    logic                    last_s;
    logic                    samp_s;
    logic                    bit_s;
    logic                    final_stop_s;
    logic                    exp_par_s;
    logic [DATA_WIDTH-1:0]   mask_s;
    logic                    end_stop_err_s;
    logic                    end_brk_s;

    // Counter landmarks: three samples centred on mid-bit, decision on the last.
    assign half_s    = {1'b0, presc_r[PRESCALE_W-1:1]};
    assign dec_cnt_s = half_s + CNT_ONE;
    assign dec_s     = (edge_cnt_r == dec_cnt_s);
    assign last_s    = (edge_cnt_r == (presc_r - CNT_ONE));
    assign samp_s    = (edge_cnt_r == (half_s - CNT_ONE)) || (edge_cnt_r == half_s) || dec_s;
    // Third vote is the live line value at the decision count.
    assign bit_s     = majority3(samp_r[1], samp_r[0], RX_IN);

    assign final_stop_s   = ~stop2_r | (bit_cnt_r == 4'd1);
    assign exp_par_s      = calc_parity(shift_r) ^ par_type_r;
    assign mask_s         = DATA_ONE << bit_cnt_r;
    assign end_stop_err_s = stop_err_r | ~bit_s;
    // Break needs the first stop bit low; with two stop bits it was folded in earlier.
    assign end_brk_s      = (bit_cnt_r == 4'd0) ? (all_low_r & ~bit_s) : all_low_r;

    // Receive FSM with edge/bit counters, sample shift and registered output pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r        <= ST_IDLE;
            edge_cnt_r     <= CNT_ZERO;
            presc_r        <= CNT_ZERO;
            bit_cnt_r      <= 4'd0;
            par_en_r       <= 1'b0;
            par_type_r     <= 1'b0;
            stop2_r        <= 1'b0;
            samp_r         <= 2'b00;
            shift_r        <= DATA_ZERO;
            p_data_r       <= DATA_ZERO;
            par_err_r      <= 1'b0;
            stop_err_r     <= 1'b0;
            all_low_r      <= 1'b0;
            data_valid_r   <= 1'b0;
            parity_error_r <= 1'b0;
            stop_error_r   <= 1'b0;
            break_detect_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            data_valid_r   <= 1'b0;
            parity_error_r <= 1'b0;
            stop_error_r   <= 1'b0;
            break_detect_r <= 1'b0;

            if (state_r != ST_IDLE) begin
                edge_cnt_r <= last_s ? CNT_ZERO : (edge_cnt_r + CNT_ONE);
                if (samp_s) begin
                    samp_r <= {samp_r[0], RX_IN};
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (!RX_IN) begin
                        state_r    <= ST_START;
                        busy_r     <= 1'b1;
                        edge_cnt_r <= CNT_ZERO;
                        bit_cnt_r  <= 4'd0;
                        presc_r    <= prescale;
                        par_en_r   <= parity_enable;
                        par_type_r <= parity_type;
                        stop2_r    <= stop_bits;
                        par_err_r  <= 1'b0;
                        stop_err_r <= 1'b0;
                        all_low_r  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (dec_s && bit_s) begin
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                        edge_cnt_r <= CNT_ZERO;
                    end else if (last_s) begin
                        state_r    <= ST_DATA;
                        edge_cnt_r <= CNT_ZERO;
                        bit_cnt_r  <= 4'd0;
                    end
                end
                ST_DATA: begin
                    if (dec_s) begin
                        shift_r   <= bit_s ? (shift_r | mask_s) : (shift_r & ~mask_s);
                        all_low_r <= all_low_r & ~bit_s;
                    end
                    if (last_s) begin
                        edge_cnt_r <= CNT_ZERO;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r   <= par_en_r ? ST_PARITY : ST_STOP;
                            bit_cnt_r <= 4'd0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (dec_s) begin
                        all_low_r <= all_low_r & ~bit_s;
                        if (bit_s != exp_par_s) begin
                            par_err_r <= 1'b1;
                        end
                    end
                    if (last_s) begin
                        state_r    <= ST_STOP;
                        edge_cnt_r <= CNT_ZERO;
                        bit_cnt_r  <= 4'd0;
                    end
                end
                ST_STOP: begin
                    // Leave at the final decision so a following start bit is not missed.
                    if (final_stop_s && (dec_s || last_s)) begin
                        state_r        <= ST_IDLE;
                        busy_r         <= 1'b0;
                        edge_cnt_r     <= CNT_ZERO;
                        bit_cnt_r      <= 4'd0;
                        data_valid_r   <= ~par_err_r & ~end_stop_err_s;
                        parity_error_r <= par_err_r;
                        stop_error_r   <= end_stop_err_s;
                        break_detect_r <= end_brk_s;
                        if (!par_err_r && !end_stop_err_s) begin
                            p_data_r <= shift_r;
                        end
                    end else begin
                        if (dec_s) begin
                            if (!bit_s) begin
                                stop_err_r <= 1'b1;
                            end
                            if (bit_cnt_r == 4'd0) begin
                                all_low_r <= all_low_r & ~bit_s;
                            end
                        end
                        if (last_s) begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    edge_cnt_r <= CNT_ZERO;
                    bit_cnt_r  <= 4'd0;
                end
            endcase
        end
    end

    assign P_DATA       = p_data_r;
    assign data_valid   = data_valid_r;
    assign parity_error = parity_error_r;
    assign stop_error   = stop_error_r;
    assign break_detect = break_detect_r;
    assign busy         = busy_r;

endmodule
